// File: rtl/vit_pkg.sv
// Shared types and constants for the Viterbi decoder frame-level control path.
package vit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ACS,
      TB_REQ,
      TB_WAIT,
      DONE
   } vit_ctrl_state_e;

   localparam int unsigned BLOCK_LEN_DEF = 16;

   // Path-metric value loaded into every non-zero state when acs_clear pulses.
   localparam logic [7:0] PM_INIT_MAX = '1;

endpackage

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2 Viterbi decoder: accepts symbol pairs,
// strobes ACS/survivor writes per trellis step, then runs one traceback per frame.
module viterbi_frame_ctrl
   import vit_pkg::*;
#(
   parameter  int unsigned BLOCK_LEN = BLOCK_LEN_DEF,
   localparam int unsigned ADDR_W    = $clog2(BLOCK_LEN),
   localparam int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        rx_pair,
   output logic [1:0]        bm_rx_pair,
   output logic              acs_clear,
   output logic              acs_en,
   output logic              sm_wr_en,
   output logic [ADDR_W-1:0] sm_wr_addr,
   output logic              tb_start,
   output logic [ADDR_W-1:0] tb_end_addr,
   input  logic              tb_done,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(BLOCK_LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BLOCK_LEN - 1);

   vit_ctrl_state_e  state;
   vit_ctrl_state_e  state_nxt;
   logic [CNT_W-1:0] step_cnt;
   logic             accept;

   // abort gates in_ready combinationally so no pair is consumed in the abort cycle.
   assign in_ready    = (state == ACS) && (step_cnt < LEN_C) && !abort;
   assign accept      = in_valid && in_ready;
   assign tb_end_addr = ADDR_W'(BLOCK_LEN - 1);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = INIT;
         INIT:    state_nxt = ACS;
         ACS:     if (accept && (step_cnt == LAST_C)) state_nxt = TB_REQ;
         TB_REQ:  state_nxt = TB_WAIT;
         TB_WAIT: if (tb_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         step_cnt   <= '0;
         bm_rx_pair <= '0;
         acs_clear  <= 1'b0;
         acs_en     <= 1'b0;
         sm_wr_en   <= 1'b0;
         sm_wr_addr <= '0;
         tb_start   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         acs_clear  <= (state == IDLE) && (state_nxt == INIT);
         acs_en     <= accept;
         sm_wr_en   <= accept;
         // tb_start follows TB_REQ so it lands strictly after the final survivor write.
         tb_start   <= (state == TB_REQ) && !abort;
         frame_done <= (state == TB_WAIT) && (state_nxt == DONE);
         busy       <= (state_nxt != IDLE);
         if (accept) begin
            bm_rx_pair <= rx_pair;
            sm_wr_addr <= step_cnt[ADDR_W-1:0];
         end
         if (abort || (state == IDLE) || (state == INIT)) begin
            step_cnt <= '0;
         end else if (accept) begin
            step_cnt <= step_cnt + CNT_W'(1);
         end
      end
   end

endmodule
